matmul_dot_accum: RTL and testbench
===================================

Name: matmul_dot_accum

Overview:
- Downstream stage of the kernel's unsigned 33x30->63-bit product multiplier.
- Consumes a stream of products and sums K of them into one wide unsigned accumulator, producing one element of C = A*B.
- Emits that element over a valid/ready handshake to the result write-back stage.
- One dot product in flight at a time; a per-job length is loaded through a config handshake.

Parameters:
- PROD_WIDTH, 63, width of incoming unsigned product.
- ACC_WIDTH, 73, accumulator/result width (PROD_WIDTH + 10 guard bits).
- CNT_WIDTH, 11, width of k_len; supports K up to 1024.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new job length present.
- cfg_ready  out  1  block idle and accepting a job.
- cfg_k_len  in  CNT_WIDTH  number of products in this dot product (0..1024).
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  block accepts product beat.
- prod_data  in  PROD_WIDTH  unsigned product from multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  ACC_WIDTH  accumulated sum.
- res_ovf  out  1  accumulator saturated during this job.

Behaviour:
- Interface: one clock, ap_clk; reset ap_rst is synchronous and active-high.
- FSM states IDLE, ACCUM, HOLD. Reset -> IDLE; acc=0, cnt=0, ovf=0.
- Reset values of outputs: cfg_ready=1, prod_ready=0, res_valid=0, res_data=0, res_ovf=0.
- Transfer occurs on a cycle where valid&&ready are both high at the rising edge.
- IDLE:
  - cfg_ready=1, prod_ready=0.
  - On cfg transfer: latch k_len, clear acc and ovf.
  - k_len==0 -> HOLD with res_data=0.
  - Otherwise -> ACCUM with cnt=0.
- ACCUM:
  - cfg_ready=0, prod_ready=1.
  - Each product transfer: acc <= sat(acc + prod_data), cnt <= cnt+1.
  - The transfer where cnt==k_len-1 moves to HOLD. res_data holds the final sum and res_valid=1 on the next cycle (1-cycle latency from last beat).
  - No transfer: state held, no change.
- HOLD:
  - res_valid=1, prod_ready=0, cfg_ready=0.
  - res_data and res_ovf stable until transfer.
  - On res transfer -> IDLE; res_valid drops the next cycle.
- Arithmetic:
  - prod_data is zero-extended to ACC_WIDTH.
  - If the ACC_WIDTH+1-bit sum exceeds 2^ACC_WIDTH-1: acc saturates to all-ones, and ovf is set and sticky for the job.
  - With 10 guard bits, saturation is unreachable for K<=1024 legal inputs; it is kept as a safety net.
- Boundary conditions:
  - prod_valid asserted in IDLE/HOLD is ignored (not consumed).
  - cfg_valid outside IDLE is ignored and cfg_ready stays low.
  - ap_rst in any state returns to IDLE next edge and drops any partial sum or pending result.
  - k_len=1024 requires cnt to reach 1023; cnt never wraps.
- prod_ready and cfg_ready are pure functions of state (no combinational path from valid inputs).

Decomposition:
- Shared package matmul_pkg holds:
  - localparams PROD_WIDTH=63, ACC_WIDTH=73, CNT_WIDTH=11, K_MAX=1024.
  - Enumerated state type {IDLE, ACCUM, HOLD}.
- One natural sub-module: matmul_sat_add (ACC_WIDTH unsigned saturating adder with overflow flag), combinational.
- FSM, counter and registers stay in the top module.

Test Plan:
- Basic: cfg k_len=4, products 1,2,3,4 streamed back-to-back, res_ready=1 -> res_valid one cycle after 4th beat, res_data=10, res_ovf=0, cfg_ready high the cycle after the result transfer.
- Max values: k_len=1024, every prod_data=2^63-1 -> res_data=1024*(2^63-1)=2^73-2^10, res_ovf=0.
- Zero length: k_len=0 -> no product consumed (prod_ready stays 0), res_valid next cycle with res_data=0.
- Backpressure: k_len=2, products 5,7, res_ready held low 6 cycles -> res_valid/res_data=12 stable all 6 cycles; extra prod_valid beats not consumed; transfer when res_ready=1.
- Bubbly input: k_len=3, prod_valid toggled randomly, values 100,200,300 -> res_data=600; cycles without a transfer leave acc unchanged.
- Reset mid-job: k_len=8, reset after 3 beats -> next cycle cfg_ready=1, res_valid=0; new job k_len=1, prod 9 -> res_data=9.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the dot-product accumulator: widths, job limits and FSM state type.
package matmul_pkg;

    localparam int PROD_WIDTH = 63;
    localparam int ACC_WIDTH  = 73;
    localparam int CNT_WIDTH  = 11;
    localparam int K_MAX      = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_dot_accum_if.sv
// Config, product and result handshakes of the accumulator, bundled as one interface.
interface matmul_dot_accum_if;
    import matmul_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CNT_WIDTH-1:0]  cfg_k_len;

    logic                  prod_valid;
    logic                  prod_ready;
    logic [PROD_WIDTH-1:0] prod_data;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  res_ovf;

    // master drives jobs/products and consumes results; slave is the accumulator
    modport master (
        output cfg_valid, cfg_k_len, prod_valid, prod_data, res_ready,
        input  cfg_ready, prod_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  cfg_valid, cfg_k_len, prod_valid, prod_data, res_ready,
        output cfg_ready, prod_ready, res_valid, res_data, res_ovf
    );

endinterface

// File: rtl/matmul_sat_add.sv
// Unsigned ACC_WIDTH saturating adder; ovf flags that the true sum did not fit.
module matmul_sat_add
    import matmul_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] y,
    output logic                 ovf
);

    logic [ACC_WIDTH:0] sum_full;

    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b};
        ovf      = sum_full[ACC_WIDTH];
        y        = ovf ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/matmul_dot_accum.sv
// Sums k_len unsigned products into one saturating accumulator and hands the result downstream.
module matmul_dot_accum
    import matmul_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    matmul_dot_accum_if.slave  bus
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] k_len_q, k_len_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [ACC_WIDTH-1:0] acc_q,   acc_d;
    logic                 ovf_q,   ovf_d;

    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 sum_ovf;
    logic                 cfg_fire;
    logic                 prod_fire;
    logic                 res_fire;
    logic                 last_beat;

    matmul_sat_add u_sat_add (
        .a   (acc_q),
        .b   ({{(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.prod_data}),
        .y   (sum_sat),
        .ovf (sum_ovf)
    );

    // Ready/valid are decoded from state only, so a fire is just valid in the right state.
    assign cfg_fire  = (state_q == IDLE)  && bus.cfg_valid;
    assign prod_fire = (state_q == ACCUM) && bus.prod_valid;
    assign res_fire  = (state_q == HOLD)  && bus.res_ready;
    assign last_beat = (cnt_q == k_len_q - CNT_WIDTH'(1));

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            k_len_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every target gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    k_len_d = bus.cfg_k_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.cfg_k_len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_fire) begin
                    acc_d = sum_sat;
                    ovf_d = ovf_q | sum_ovf;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (res_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready  = (state_q == IDLE);
        bus.prod_ready = (state_q == ACCUM);
        bus.res_valid  = (state_q == HOLD);
        bus.res_data   = acc_q;
        bus.res_ovf    = ovf_q;
    end

endmodule

// File: tb/tb_matmul_dot_accum.sv
// Scoreboard bench for matmul_dot_accum: expected sums queued per job, checked on each result transfer.
module tb_matmul_dot_accum;
    import matmul_pkg::*;

    typedef struct {
        logic [ACC_WIDTH-1:0] data;
        logic                 ovf;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;
    exp_t exp_q[$];

    matmul_dot_accum_if bus ();

    matmul_dot_accum dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    // Inputs change 1 time unit after the rising edge, so the falling edge sees settled values.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.res_valid && bus.res_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got data=%0h with no job queued", bus.res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.res_data !== e.data || bus.res_ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL result: got data=%0h ovf=%b, expected data=%0h ovf=%b",
                             bus.res_data, bus.res_ovf, e.data, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic exp_t model(input logic [PROD_WIDTH-1:0] vals[$]);
        logic [ACC_WIDTH:0] s;
        exp_t r;
        s     = '0;
        r.ovf = 1'b0;
        foreach (vals[i]) begin
            s = s + {{(ACC_WIDTH+1-PROD_WIDTH){1'b0}}, vals[i]};
            if (s[ACC_WIDTH]) begin
                s     = {1'b0, {ACC_WIDTH{1'b1}}};
                r.ovf = 1'b1;
            end
        end
        r.data = s[ACC_WIDTH-1:0];
        return r;
    endfunction

    task automatic send_cfg(input int k);
        int guard = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_k_len = CNT_WIDTH'(k);
        while (!bus.cfg_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL cfg_timeout: cfg_ready=%b after %0d cycles, expected 1", bus.cfg_ready, guard);
        end
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_prod(input logic [PROD_WIDTH-1:0] d);
        int guard = 0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        while (!bus.prod_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL prod_timeout: prod_ready=%b after %0d cycles, expected 1", bus.prod_ready, guard);
        end
        tick();
        bus.prod_valid = 1'b0;
    endtask

    task automatic run_job(input int k, input logic [PROD_WIDTH-1:0] vals[$], input bit bubbly);
        exp_q.push_back(model(vals));
        send_cfg(k);
        foreach (vals[i]) begin
            if (bubbly) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.prod_valid = 1'b0;
                    bus.prod_data  = PROD_WIDTH'($urandom);
                    tick();
                end
            end
            send_prod(vals[i]);
        end
    endtask

    task automatic drain();
        int guard = 0;
        bus.res_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (3) tick();
        n_cmp += 5;
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready: got %b want 1", bus.cfg_ready); end
        if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL rst_prod_ready: got %b want 0", bus.prod_ready); end
        if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        if (bus.res_data !== '0) begin n_err++; $display("FAIL rst_res_data: got %0h want 0", bus.res_data); end
        if (bus.res_ovf !== 1'b0) begin n_err++; $display("FAIL rst_res_ovf: got %b want 0", bus.res_ovf); end
        ap_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [PROD_WIDTH-1:0] v[$];
        v = '{63'd1, 63'd2, 63'd3, 63'd4};
        bus.res_ready = 1'b1;
        run_job(4, v, 1'b0);
        n_cmp++;
        if (bus.res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: res_valid=%b one cycle after last beat, want 1", bus.res_valid);
        end
        tick();
        n_cmp++;
        if (bus.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_cfg_ready: got %b after result transfer, want 1", bus.cfg_ready);
        end
        drain();
    endtask

    task automatic test_max();
        logic [PROD_WIDTH-1:0] v[$];
        for (int i = 0; i < K_MAX; i++) v.push_back({PROD_WIDTH{1'b1}});
        bus.res_ready = 1'b1;
        run_job(K_MAX, v, 1'b0);
        drain();
    endtask

    task automatic test_zero_len();
        logic [PROD_WIDTH-1:0] v[$];
        bus.res_ready  = 1'b0;
        exp_q.push_back(model(v));
        bus.prod_valid = 1'b1;
        bus.prod_data  = 63'd55;
        send_cfg(0);
        bus.prod_valid = 1'b1;
        n_cmp += 2;
        if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL zero_res_valid: got %b want 1", bus.res_valid); end
        if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL zero_prod_ready: got %b want 0", bus.prod_ready); end
        bus.prod_valid = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [PROD_WIDTH-1:0] v[$];
        v = '{63'd5, 63'd7};
        bus.res_ready = 1'b0;
        run_job(2, v, 1'b0);
        bus.prod_valid = 1'b1;
        bus.prod_data  = 63'd99;
        bus.cfg_valid  = 1'b1;
        bus.cfg_k_len  = CNT_WIDTH'(3);
        for (int c = 0; c < 6; c++) begin
            n_cmp += 4;
            if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.res_valid); end
            if (bus.res_data !== ACC_WIDTH'(12)) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want 12", c, bus.res_data); end
            if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL bp_prod_ready[%0d]: got %b want 0", c, bus.prod_ready); end
            if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL bp_cfg_ready[%0d]: got %b want 0", c, bus.cfg_ready); end
            tick();
        end
        bus.prod_valid = 1'b0;
        bus.cfg_valid  = 1'b0;
        drain();
    endtask

    task automatic test_bubbly();
        logic [PROD_WIDTH-1:0] v[$];
        v = '{63'd100, 63'd200, 63'd300};
        bus.res_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            run_job(3, v, 1'b1);
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [PROD_WIDTH-1:0] v[$];
        bus.res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            v.delete();
            for (int i = 0; i <= j; i++) v.push_back(PROD_WIDTH'({$urandom, $urandom}));
            run_job(j + 1, v, 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_mid_job();
        logic [PROD_WIDTH-1:0] v[$];
        bus.res_ready = 1'b1;
        send_cfg(8);
        send_prod(63'd11);
        send_prod(63'd22);
        send_prod(63'd33);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        n_cmp += 3;
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_cfg_ready: got %b want 1", bus.cfg_ready); end
        if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_res_valid: got %b want 0", bus.res_valid); end
        if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL midrst_prod_ready: got %b want 0", bus.prod_ready); end
        v = '{63'd9};
        run_job(1, v, 1'b0);
        drain();
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_k_len  = '0;
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.res_ready  = 1'b0;

        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_bubbly();
        test_back_to_back();
        test_max();
        test_reset_mid_job();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected results never produced", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
